// File: rtl/npc_ras_unit.sv
// Next-PC select + PC register + circular return-address stack; pc follows npc one cycle later.
// stall_i holds pc and RAS, flush_i redirects; the RAS exists only when NPC_RAS_EN is defined.
module npc_ras_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter int          RAS_AW   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic [31:0]       flush_pc_i,
   input  logic [2:0]        npc_op,
   input  logic [25:0]       imm,
   input  logic [31:0]       rf_in,
   output logic [31:0]       pc,
   output logic [31:0]       pc_plus4,
   output logic [31:0]       npc,
   output logic [31:0]       ras_top,
   output logic [RAS_AW:0]   ras_count,
   output logic              ras_hit,
   output logic              ras_ovf
);

   localparam logic [2:0] OP_BRANCH = 3'd1;
   localparam logic [2:0] OP_JUMP   = 3'd2;
   localparam logic [2:0] OP_RF     = 3'd3;
   localparam logic [2:0] OP_CALL   = 3'd4;
   localparam logic [2:0] OP_RET    = 3'd5;

   logic [31:0] pc_q, pc_d;
   logic [31:0] br_off, jmp_tgt, rf_tgt, ret_tgt, op_tgt;
   logic        unused_bits;

   assign unused_bits = ^{rf_in[1:0], flush_pc_i[1:0]};

   assign pc       = pc_q;
   assign pc_plus4 = pc_q + 32'd4;
   assign br_off   = {{14{imm[15]}}, imm[15:0], 2'b00};
   assign jmp_tgt  = {pc_plus4[31:28], imm, 2'b00};
   assign rf_tgt   = {rf_in[31:2], 2'b00};

`ifdef NPC_RAS_EN
   localparam logic [RAS_AW-1:0] SP_ONE   = RAS_AW'(1);
   localparam logic [RAS_AW:0]   CNT_ONE  = (RAS_AW+1)'(1);
   localparam logic [RAS_AW:0]   CNT_FULL = (RAS_AW+1)'(2**RAS_AW);

   logic [31:0]       mem_q [2**RAS_AW];
   logic [RAS_AW-1:0] sp_q, sp_d, sp_m1;
   logic [RAS_AW:0]   cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              advance, push, pop;

   assign sp_m1     = sp_q - SP_ONE;
   assign ras_top   = (cnt_q != '0) ? mem_q[sp_m1] : 32'd0;
   assign ras_count = cnt_q;
   assign ras_ovf   = ovf_q;
   assign ras_hit   = (npc_op == OP_RET) && (cnt_q != '0);
   assign ret_tgt   = ras_hit ? ras_top : rf_tgt;

   assign advance = !rst && !flush_i && !stall_i;
   assign push    = advance && (npc_op == OP_CALL);
   assign pop     = advance && ras_hit;

   always_comb begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (push) begin
         // A full stack wraps over its oldest entry rather than refusing the push.
         sp_d = sp_q + SP_ONE;
         if (cnt_q == CNT_FULL) ovf_d = 1'b1;
         else                   cnt_d = cnt_q + CNT_ONE;
      end else if (pop) begin
         sp_d  = sp_m1;
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[sp_q] <= pc_plus4;
   end
`else
   assign ras_top   = 32'd0;
   assign ras_count = '0;
   assign ras_hit   = 1'b0;
   assign ras_ovf   = 1'b0;
   assign ret_tgt   = rf_tgt;
`endif

   always_comb begin
      op_tgt = pc_plus4;
      case (npc_op)
         OP_BRANCH:        op_tgt = pc_plus4 + br_off;
         OP_JUMP, OP_CALL: op_tgt = jmp_tgt;
         OP_RF:            op_tgt = rf_tgt;
         OP_RET:           op_tgt = ret_tgt;
         default:          op_tgt = pc_plus4;
      endcase
   end

   always_comb begin
      npc = op_tgt;
      if (flush_i)      npc = {flush_pc_i[31:2], 2'b00};
      else if (stall_i) npc = pc_q;
   end

   assign pc_d = npc;

   always_ff @(posedge clk) begin
      if (rst) pc_q <= {RESET_PC[31:2], 2'b00};
      else     pc_q <= pc_d;
   end

endmodule

// File: tb/tb_npc_ras_unit.sv
// Directed + random bench for npc_ras_unit against a queue-based model of the PC and return stack.
module tb_npc_ras_unit;
   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam int          DEPTH  = 4;
`ifdef NPC_RAS_EN
   localparam bit RAS_EN = 1'b1;
`else
   localparam bit RAS_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
   logic [31:0] flush_pc_i = '0;
   logic [2:0]  npc_op = '0;
   logic [25:0] imm = '0;
   logic [31:0] rf_in = '0;
   logic [31:0] pc, pc_plus4, npc, ras_top;
   logic [2:0]  ras_count;
   logic        ras_hit, ras_ovf;

   npc_ras_unit #(.RESET_PC(RST_PC), .RAS_AW(2)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
      .npc_op(npc_op), .imm(imm), .rf_in(rf_in), .pc(pc), .pc_plus4(pc_plus4), .npc(npc),
      .ras_top(ras_top), .ras_count(ras_count), .ras_hit(ras_hit), .ras_ovf(ras_ovf)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0, n_bad = 0;
   logic [31:0] pc_m;
   logic [31:0] ras_m[$];
   bit          ovf_m = 1'b0;
   bit          mvalid = 1'b0;

   function automatic logic [31:0] op_target();
      logic [31:0] p4 = pc_m + 32'd4;
      case (npc_op)
         3'd1: return p4 + 32'($signed(imm[15:0])) * 32'd4;
         3'd2, 3'd4: return (p4 & 32'hF000_0000) | (32'(imm) << 2);
         3'd3: return rf_in & ~32'd3;
         3'd5: return (RAS_EN && ras_m.size() > 0) ? ras_m[$] : (rf_in & ~32'd3);
         default: return p4;
      endcase
   endfunction

   function automatic logic [31:0] exp_npc();
      if (flush_i) return flush_pc_i & ~32'd3;
      if (stall_i) return pc_m;
      return op_target();
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit r, input bit f, input logic [31:0] fpc, input bit s,
                      input logic [2:0] op, input logic [25:0] im, input logic [31:0] rf);
      logic [31:0] nxt;
      bit          hit;
      rst = r; flush_i = f; flush_pc_i = fpc; stall_i = s; npc_op = op; imm = im; rf_in = rf;
      #2;
      nxt = exp_npc();
      hit = RAS_EN && (op == 3'd5) && (ras_m.size() > 0);
      if (mvalid) begin
         check("npc", npc, nxt);
         check("pc_plus4", pc_plus4, pc_m + 32'd4);
         check("ras_hit", 32'(ras_hit), 32'(hit));
      end
      @(posedge clk);
      if (r) begin
         pc_m = RST_PC;
         ras_m.delete();
         ovf_m = 1'b0;
         mvalid = 1'b1;
      end else if (f) begin
         pc_m = fpc & ~32'd3;
      end else if (!s) begin
         if (RAS_EN && op == 3'd4) begin
            ras_m.push_back(pc_m + 32'd4);
            if (ras_m.size() > DEPTH) begin
               void'(ras_m.pop_front());
               ovf_m = 1'b1;
            end
         end else if (hit) begin
            void'(ras_m.pop_back());
         end
         pc_m = nxt;
      end
      #1;
      if (mvalid) begin
         check("pc", pc, pc_m);
         check("ras_count", 32'(ras_count), 32'(ras_m.size()));
         check("ras_top", ras_top, (ras_m.size() > 0) ? ras_m[$] : 32'd0);
         check("ras_ovf", 32'(ras_ovf), 32'(ovf_m));
      end
   endtask

   task automatic op_step(input logic [2:0] op, input logic [25:0] im, input logic [31:0] rf);
      cyc(1'b0, 1'b0, 32'd0, 1'b0, op, im, rf);
   endtask

   initial begin
      #1;
      cyc(1'b1, 1'b0, 32'd0, 1'b0, 3'd0, 26'd0, 32'd0);
      check("reset_pc", pc, 32'h0000_3000);
      check("reset_cnt", 32'(ras_count), 32'd0);
      repeat (3) op_step(3'd0, 26'd0, 32'd0);
      check("normal_pc", pc, 32'h0000_300C);
      op_step(3'd0, 26'd0, 32'd0);
      op_step(3'd1, 26'h000FFFC, 32'd0);
      check("branch_back", pc, 32'h0000_3004);
      op_step(3'd2, 26'h0000100, 32'd0);
      check("jump_pc", pc, 32'h0000_0400);

      cyc(1'b1, 1'b0, 32'd0, 1'b0, 3'd0, 26'd0, 32'd0);
      op_step(3'd4, 26'h40, 32'd0);
      check("call_pc", pc, 32'h0000_0100);
      op_step(3'd5, 26'd0, 32'h0000_DEAD);
      op_step(3'd5, 26'd0, 32'h0000_2003);
      check("ret_fallback", pc, 32'h0000_2000);

      for (int k = 1; k <= 5; k++) op_step(3'd4, 26'(k * 32'h400), 32'd0);
      repeat (4) op_step(3'd5, 26'd0, 32'h0000_1234);

      op_step(3'd4, 26'h80, 32'd0);
      repeat (2) cyc(1'b0, 1'b0, 32'd0, 1'b1, 3'd2, 26'h123, 32'd0);
      check("stall_pc", pc, 32'h0000_0200);
      cyc(1'b0, 1'b1, 32'h8000_0183, 1'b1, 3'd2, 26'h123, 32'd0);
      check("flush_pc", pc, 32'h8000_0180);

      repeat (3) op_step(3'd4, 26'h55, 32'd0);
      cyc(1'b1, 1'b1, 32'h0000_4000, 1'b1, 3'd4, 26'h7, 32'd0);
      check("rst_pc", pc, 32'h0000_3000);
      check("rst_cnt", 32'(ras_count), 32'd0);

      for (int i = 0; i < 400; i++) begin
         cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom,
             $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), 26'($urandom), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
